// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: valid/ready load/store request and response channels.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle RV32 byte/half/word load-store memory behind a valid/ready port.
// Define DMEM_ALIGN_CHECK_EN to report misaligned or illegal-funct3 accesses as errors.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave mem_if
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rdy_q;
  logic          we_q, we_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          acc, idle, bad;
  logic          a_we;
  logic [AW+1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [2:0]    a_f3;
  logic [1:0]    sz;
  logic [31:0]   word_r, ld, wd;
  logic [15:0]   half_r;
  logic [7:0]    byte_r;
  logic [3:0]    be;
  logic [31:0]   mem [DEPTH_WORDS];
  // A zero-latency access happens on the accept edge, so it must see the live bus fields.
  assign idle    = state_q == IDLE;
  assign a_we    = idle ? mem_if.req_we : we_q;
  assign a_addr  = idle ? mem_if.req_addr[AW+1:0] : addr_q;
  assign a_wdata = idle ? mem_if.req_wdata : wdata_q;
  assign a_f3    = idle ? mem_if.req_func3 : f3_q;
  assign sz      = a_f3[1:0] == 2'b00 ? 2'd0 : a_f3[1:0] == 2'b01 ? 2'd1 : 2'd2;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = a_f3[1:0] == 2'b11 || a_f3 == 3'b110 ||
               (sz == 2'd1 && a_addr[0]) || (sz == 2'd2 && a_addr[1:0] != 2'b00);
`else
  assign bad = 1'b0;
`endif
  assign word_r = mem[a_addr[AW+1:2]];
  assign byte_r = word_r[{a_addr[1:0], 3'b000} +: 8];
  assign half_r = a_addr[1] ? word_r[31:16] : word_r[15:0];
  assign ld     = sz == 2'd0 ? {{24{~a_f3[2] & byte_r[7]}}, byte_r} :
                  sz == 2'd1 ? {{16{~a_f3[2] & half_r[15]}}, half_r} : word_r;
  assign wd     = sz == 2'd0 ? {4{a_wdata[7:0]}} : sz == 2'd1 ? {2{a_wdata[15:0]}} : a_wdata;
  assign be     = (bad || !a_we) ? 4'b0000 :
                  sz == 2'd0 ? 4'b0001 << a_addr[1:0] :
                  sz == 2'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign mem_if.req_ready = rdy_q && idle;
  assign mem_if.rsp_valid = state_q == RESP;
  assign mem_if.rsp_rdata = rdata_q;
  assign mem_if.rsp_err   = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    acc     = 1'b0;
    case (state_q)
      IDLE: if (mem_if.req_valid && rdy_q) begin
        we_d    = mem_if.req_we;
        addr_d  = mem_if.req_addr[AW+1:0];
        wdata_d = mem_if.req_wdata;
        f3_d    = mem_if.req_func3;
        cnt_d   = 4'(LATENCY);
        acc     = LATENCY == 0;
        state_d = acc ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        acc     = cnt_q == 4'd1;
        state_d = acc ? RESP : WAIT;
      end
      RESP: state_d = mem_if.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    rdata_d = acc ? ((a_we || bad) ? 32'd0 : ld) : rdata_q;
    err_d   = acc ? bad : err_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  // Array is never reset; acc is held low by reset so no store can land mid-reset.
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (acc && be[i]) mem[a_addr[AW+1:2]][i*8 +: 8] <= wd[i*8 +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed load/store traffic against a byte-array reference model.
module tb_data_mem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mb [4096];
  data_mem_responder_if b ();
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .mem_if(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] d, output logic e);
    int sz, a;
    logic [31:0] v;
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    e = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    e = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (int'(addr[1:0]) % sz) != 0;
`endif
    a = int'(addr[11:0]);
    a = a - a % sz;
    d = '0;
    v = '0;
    if (!e) begin
      if (we) for (int i = 0; i < sz; i++) mb[a+i] = wd[8*i +: 8];
      else begin
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[a+i];
        if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
        d = v;
      end
    end
  endtask
  task automatic txn(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3, input int bp, output logic [31:0] got);
    logic [31:0] ed;
    logic ee;
    int k;
    model(we, addr, wd, f3, ed, ee);
    @(negedge clk);
    chk({tag, " ready"}, 32'(b.req_ready), 32'd1);
    b.req_valid = 1'b1; b.req_we = we; b.req_addr = addr; b.req_wdata = wd; b.req_func3 = f3;
    b.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    b.req_valid = 1'($urandom); b.req_we = 1'($urandom); b.req_addr = $urandom;
    b.req_wdata = $urandom; b.req_func3 = 3'($urandom);
    k = 0;
    @(negedge clk);
    while (!b.rsp_valid && k < 40) begin
      chk({tag, " busy"}, 32'(b.req_ready), 32'd0);
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(LAT));
    got = b.rsp_rdata;
    chk({tag, " rdata"}, got, ed);
    chk({tag, " err"}, 32'(b.rsp_err), 32'(ee));
    for (int i = 0; i < bp; i++) begin
      b.req_valid = 1'b1;
      @(negedge clk);
      chk({tag, " hold rdata"}, b.rsp_rdata, got);
      chk({tag, " hold ctl"}, {29'd0, b.rsp_valid, b.req_ready, b.rsp_err}, {29'd0, 1'b1, 1'b0, ee});
    end
    b.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    b.rsp_ready = 1'b0;
    b.req_valid = 1'b0;
    chk({tag, " done"}, 32'(b.rsp_valid), 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [31:0] r, w0, old;
    b.req_valid = 1'b0; b.req_we = 1'b0; b.req_addr = '0; b.req_wdata = '0; b.req_func3 = '0;
    b.rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst ctl", {29'd0, b.req_ready, b.rsp_valid, b.rsp_err}, 32'd0);
      chk("rst rdata", b.rsp_rdata, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("ready after rst", 32'(b.req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("idle no rsp", 32'(b.rsp_valid), 32'd0);
    end
    for (int i = 0; i < 1024; i++) txn("fill", 1'b1, 32'(i * 4), $urandom, 3'd2, 0, r);
    txn("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, r);
    chk("sw10 zero rdata", r, 32'd0);
    txn("lw10", 1'b0, 32'h10, 32'd0, 3'd2, 0, r);
    chk("lw10 value", r, 32'hDEADBEEF);
    txn("sw20", 1'b1, 32'h20, 32'h80FF7F01, 3'd2, 0, r);
    txn("lb23", 1'b0, 32'h23, 32'd0, 3'd0, 0, r);
    chk("lb23 value", r, 32'hFFFFFF80);
    txn("lbu23", 1'b0, 32'h23, 32'd0, 3'd4, 0, r);
    chk("lbu23 value", r, 32'h00000080);
    txn("lh22", 1'b0, 32'h22, 32'd0, 3'd1, 0, r);
    chk("lh22 value", r, 32'hFFFF80FF);
    txn("lhu22", 1'b0, 32'h22, 32'd0, 3'd5, 0, r);
    chk("lhu22 value", r, 32'h000080FF);
    txn("lb20", 1'b0, 32'h20, 32'd0, 3'd0, 0, r);
    chk("lb20 value", r, 32'h00000001);
    txn("lw0", 1'b0, 32'h0, 32'd0, 3'd2, 0, w0);
    txn("sb1001", 1'b1, 32'h1001, 32'h000000AA, 3'd0, 0, r);
    txn("lw0 after sb", 1'b0, 32'h0, 32'd0, 3'd2, 0, r);
    chk("wrap lane1", r, {w0[31:16], 8'hAA, w0[7:0]});
    txn("bp", 1'b0, 32'h10, 32'd0, 3'd2, 5, r);
    chk("bp value", r, 32'hDEADBEEF);
    txn("lw40", 1'b0, 32'h40, 32'd0, 3'd2, 0, old);
    txn("sw42", 1'b1, 32'h42, 32'h12345678, 3'd2, 0, r);
    txn("lw40 after sw42", 1'b0, 32'h40, 32'd0, 3'd2, 0, r);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misalign untouched", r, old);
`else
    chk("misalign written", r, 32'h12345678);
`endif
    txn("lw80", 1'b0, 32'h80, 32'd0, 3'd2, 0, old);
    @(negedge clk);
    b.req_valid = 1'b1; b.req_we = 1'b1; b.req_addr = 32'h80; b.req_wdata = ~old; b.req_func3 = 3'd2;
    @(posedge clk);
    #1;
    b.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst in wait ctl", {29'd0, b.req_ready, b.rsp_valid, b.rsp_err}, 32'd0);
    chk("rst in wait rdata", b.rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    txn("lw80 after rst", 1'b0, 32'h80, 32'd0, 3'd2, 0, r);
    chk("aborted store", r, old);
    repeat (400) txn("rnd", 1'($urandom), $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), r);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
